// File: rtl/alu_control_md.sv
// alu_control_md: EX-stage ALU with decoded control, single-cycle integer ops,
// and iterative signed/unsigned multiply and divide into architectural HI/LO.
//
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both high. The operands and opcode are sampled only on that
// edge. in_ready is low while a multiply/divide is in flight. out_valid is a
// single-cycle pulse with no backpressure. result and the flags are registered
// together with it, and they hold their values after the pulse ends.
module alu_control_md #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   work;      // mul: {acc, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     a_raw;     // dividend as given, for divide by zero
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic                 neg_q;     // product or quotient must be negated
    logic                 neg_r;     // remainder must be negated
    logic                 div_zero;
    logic                 mode_div;

    // Single-cycle decode
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic                 slt_s;
    logic                 slt_u;
    logic [WIDTH-1:0]     sc_res;
    logic                 sc_ovf;
    logic                 sc_ill;
    logic                 start_mul;
    logic                 start_div;
    logic                 md_signed;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    // Iteration and sign fix-up
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    assign in_ready  = (state == IDLE);
    assign busy      = ~in_ready;
    assign state_dbg = state;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign slt_s   = ($signed(a) < $signed(b));
    assign slt_u   = (a < b);

    // Decode alu_op/func_code into a single-cycle result or a mult/div start
    always_comb begin
        sc_res    = '0;
        sc_ovf    = 1'b0;
        sc_ill    = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        md_signed = 1'b0;
        case (alu_op)
            2'b00: begin
                sc_res = sum;
                sc_ovf = add_ovf;
            end
            2'b01: begin
                sc_res = diff;
                sc_ovf = sub_ovf;
            end
            2'b10: begin
                case (func_code)
                    6'd32: begin sc_res = sum;  sc_ovf = add_ovf; end
                    6'd33: sc_res = sum;
                    6'd34: begin sc_res = diff; sc_ovf = sub_ovf; end
                    6'd35: sc_res = diff;
                    6'd36: sc_res = a & b;
                    6'd37: sc_res = a | b;
                    6'd38: sc_res = a ^ b;
                    6'd39: sc_res = ~(a | b);
                    6'd42: sc_res = {{(WIDTH-1){1'b0}}, slt_s};
                    6'd43: sc_res = {{(WIDTH-1){1'b0}}, slt_u};
                    6'd16: sc_res = hi;
                    6'd18: sc_res = lo;
                    6'd24: begin start_mul = 1'b1; md_signed = 1'b1; end
                    6'd25: start_mul = 1'b1;
                    6'd26: begin start_div = 1'b1; md_signed = 1'b1; end
                    6'd27: start_div = 1'b1;
                    default: sc_ill = 1'b1;
                endcase
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // Signed operations iterate on magnitudes; the most negative value maps
    // onto itself, which is the correct unsigned magnitude.
    assign abs_a = (md_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (md_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB is set, then shift the whole product right by one.
    assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, work[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. With a nonzero divisor the remainder
    // stays below it, so bit WIDTH of the difference is exactly the borrow.
    assign div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = div_ge ? {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                              : {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b0};

    assign prod_fix = neg_q ? -work : work;
    assign quo_fix  = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    assign rem_fix  = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

    // Select the HI/LO values written when a mult/div completes
    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (mode_div) begin
            if (div_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quo_fix;
            end
        end
    end

    // Control FSM with registered result, flags and HI/LO
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            opnd      <= '0;
            a_raw     <= '0;
            hi        <= '0;
            lo        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            mode_div  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (start_mul) begin
                            work     <= {{WIDTH{1'b0}}, abs_b};
                            opnd     <= abs_a;
                            neg_q    <= md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= 1'b0;
                            mode_div <= 1'b0;
                            cnt      <= CW'(WIDTH - 1);
                            state    <= MUL;
                        end else if (start_div) begin
                            work     <= {{WIDTH{1'b0}}, abs_a};
                            opnd     <= abs_b;
                            neg_q    <= md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= md_signed && a[WIDTH-1];
                            div_zero <= (b == '0);
                            a_raw    <= a;
                            mode_div <= 1'b1;
                            cnt      <= CW'(WIDTH - 1);
                            state    <= DIV;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            zero      <= (sc_res == '0);
                            ovf       <= sc_ovf;
                            illegal   <= sc_ill;
                        end
                    end
                end
                MUL: begin
                    work <= mul_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    work <= div_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    out_valid <= 1'b1;
                    result    <= fix_lo;
                    zero      <= (fix_lo == '0);
                    ovf       <= 1'b0;
                    illegal   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
